// File: rtl/sw_debounce4_if.sv
// Switch conditioner bus: raw switch levels in, debounced levels and edge strobes out.
// The master side is the board/stimulus; the slave side is the conditioner.
interface sw_debounce4_if;
  logic [3:0] sw_in;
  logic [3:0] sw_out;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       sw_changed;

  modport master (
    output sw_in,
    input  sw_out,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );

  modport slave (
    input  sw_in,
    output sw_out,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );
endinterface

// File: rtl/sw_debounce4.sv
// Four-channel switch synchronizer/debouncer feeding the AND-OR-NOT gate inputs {d,c,b,a}.
// Each channel follows its synchronized level after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module sw_debounce4 #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic          clk,
  input  logic          rst,
  sw_debounce4_if.slave bus
);

  localparam int N = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]     sync_p1;
  logic [N-1:0]     sync_p2;
  logic [CNT_W-1:0] cnt_p3   [N];
  logic [CNT_W-1:0] cnt_nxt  [N];
  logic [N-1:0]     out_p3;
  logic [N-1:0]     out_nxt;
  logic [N-1:0]     rise_p3;
  logic [N-1:0]     rise_nxt;
  logic [N-1:0]     fall_p3;
  logic [N-1:0]     fall_nxt;
  logic             chg_p3;

  function automatic logic hold_done(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_LAST;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    return cnt + CNT_W'(1);
  endfunction

  // Stage p1/p2: two-flop synchronizer, no logic between the flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p1 <= bus.sw_in;
      sync_p2 <= sync_p1;
    end
  end

  // Any cycle of agreement clears the count, so only an unbroken run can commit
  always_comb begin
    out_nxt  = out_p3;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = '0;
      if (sync_p2[i] != out_p3[i]) begin
        if (hold_done(cnt_p3[i])) begin
          out_nxt[i]  = sync_p2[i];
          rise_nxt[i] = sync_p2[i];
          fall_nxt[i] = ~sync_p2[i];
        end else begin
          cnt_nxt[i] = cnt_inc(cnt_p3[i]);
        end
      end
    end
  end

  // Stage p3: debounced level, counters and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt_p3[i] <= '0;
      out_p3  <= '0;
      rise_p3 <= '0;
      fall_p3 <= '0;
      chg_p3  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) cnt_p3[i] <= cnt_nxt[i];
      out_p3  <= out_nxt;
      rise_p3 <= rise_nxt;
      fall_p3 <= fall_nxt;
      chg_p3  <= |(rise_nxt | fall_nxt);
    end
  end

  assign bus.sw_out     = out_p3;
  assign bus.sw_rise    = rise_p3;
  assign bus.sw_fall    = fall_p3;
  assign bus.sw_changed = chg_p3;

endmodule

// File: tb/tb_sw_debounce4.sv
// Bench for sw_debounce4: directed scenarios plus random bounce trains against a
// sliding-window reference model of the debounce rule.
module tb_sw_debounce4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sw_debounce4_if bus ();

  sw_debounce4 #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Reference model: a channel commits when the last D edges all saw disagreement
  // and none of those edges is at or before the previous commit/reset.
  logic [3:0]   m_s1 = '0;
  logic [3:0]   m_s2 = '0;
  logic [3:0]   m_out = '0;
  logic [3:0]   e_rise = '0;
  logic [3:0]   e_fall = '0;
  logic [D-1:0] win [4];
  int           last_upd [4];

  function automatic logic [12:0] exp_vec();
    return {m_out, e_rise, e_fall, |(e_rise | e_fall)};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {bus.sw_out, bus.sw_rise, bus.sw_fall, bus.sw_changed};
  endfunction

  task automatic tick(input logic r, input logic [3:0] sw);
    logic dis;
    rst = r;
    bus.sw_in = sw;
    @(posedge clk);
    edge_n++;
    e_rise = '0;
    e_fall = '0;
    if (r) begin
      m_s1 = '0;
      m_s2 = '0;
      m_out = '0;
      for (int ch = 0; ch < 4; ch++) begin
        win[ch] = '0;
        last_upd[ch] = edge_n;
      end
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        dis = (m_s2[ch] != m_out[ch]);
        win[ch] = {win[ch][D-2:0], dis};
        if ((&win[ch]) && (edge_n - last_upd[ch] >= D)) begin
          m_out[ch] = ~m_out[ch];
          if (m_out[ch]) e_rise[ch] = 1'b1;
          else e_fall[ch] = 1'b1;
          last_upd[ch] = edge_n;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
    #1;
  endtask

  task automatic test_reset();
    int first;
    int rises;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 4'hF);
      n_cmp++;
      if (obs_vec() !== 13'h0) begin
        n_bad++;
        $display("FAIL reset_hold k=%0d got=%h want=%h", k, obs_vec(), 13'h0);
      end
    end
    first = -1;
    rises = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 4'hF);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL reset_release k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (bus.sw_rise == 4'hF) rises++;
      if (first < 0 && bus.sw_out == 4'hF) first = k;
    end
    n_cmp++;
    if (first != D + 1 || rises != 1) begin
      n_bad++;
      $display("FAIL reset_latency got idx=%0d rises=%0d want idx=%0d rises=1", first, rises, D + 1);
    end
  endtask

  task automatic test_clean_step();
    int lat_r;
    int lat_f;
    int n_r;
    int n_f;
    tick(1'b1, 4'h0);
    tick(1'b0, 4'h0);
    lat_r = -1;
    n_r = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 4'b0001);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL step_rise k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (bus.sw_rise == 4'b0001) n_r++;
      if (lat_r < 0 && bus.sw_out[0]) lat_r = k;
    end
    lat_f = -1;
    n_f = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 4'b0000);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL step_fall k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (bus.sw_fall == 4'b0001) n_f++;
      if (lat_f < 0 && !bus.sw_out[0]) lat_f = k;
    end
    n_cmp++;
    if (lat_r != D + 1 || lat_f != D + 1 || n_r != 1 || n_f != 1) begin
      n_bad++;
      $display("FAIL step_latency got r=%0d f=%0d nr=%0d nf=%0d want %0d %0d 1 1",
               lat_r, lat_f, n_r, n_f, D + 1, D + 1);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    int rises;
    tick(1'b1, 4'h0);
    pulses = 0;
    for (int k = 0; k < 11; k++) begin
      tick(1'b0, (k < D - 1) ? 4'b0010 : 4'b0000);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL glitch_short k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      pulses += (bus.sw_changed ? 1 : 0) + (bus.sw_out != 4'h0 ? 1 : 0);
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL glitch_ignored got events=%0d want 0", pulses);
    end
    rises = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, (k < D) ? 4'b0010 : 4'b0000);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL glitch_full k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (bus.sw_rise == 4'b0010) rises++;
    end
    n_cmp++;
    if (rises != 1) begin
      n_bad++;
      $display("FAIL glitch_accept got rises=%0d want 1", rises);
    end
  endtask

  task automatic test_bounce();
    logic [15:0] pat;
    int idx;
    int rises;
    pat = 16'b1111_1111_1110_1101;  // bit k = level at step k: 1,0,1,1,0,1,1,1,...
    tick(1'b1, 4'h0);
    idx = -1;
    rises = 0;
    for (int k = 0; k < 16; k++) begin
      tick(1'b0, {1'b0, pat[k], 2'b00});
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL bounce k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (bus.sw_rise[2]) begin
        rises++;
        idx = k;
      end
    end
    n_cmp++;
    if (rises != 1 || idx != 5 + D + 1) begin
      n_bad++;
      $display("FAIL bounce_pulse got rises=%0d idx=%0d want 1 %0d", rises, idx, 5 + D + 1);
    end
  endtask

  task automatic test_simultaneous();
    int chg;
    logic [3:0] seen;
    tick(1'b1, 4'h0);
    tick(1'b0, 4'h0);
    chg = 0;
    seen = '0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 4'b1010);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL simul k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (bus.sw_changed) begin
        chg++;
        seen = bus.sw_rise;
      end
    end
    n_cmp++;
    if (chg != 1 || seen != 4'b1010 || bus.sw_out != 4'b1010) begin
      n_bad++;
      $display("FAIL simul_pulse got chg=%0d rise=%b out=%b want 1 1010 1010", chg, seen, bus.sw_out);
    end
  endtask

  task automatic test_reset_mid();
    int idx;
    int rises;
    tick(1'b1, 4'h0);
    for (int k = 0; k < 3; k++) tick(1'b0, 4'b1000);
    tick(1'b1, 4'b1000);
    n_cmp++;
    if (obs_vec() !== 13'h0) begin
      n_bad++;
      $display("FAIL rstmid_clear got=%h want=%h", obs_vec(), 13'h0);
    end
    idx = -1;
    rises = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 4'b1000);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL rstmid k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (bus.sw_rise[3]) begin
        rises++;
        idx = k;
      end
    end
    n_cmp++;
    if (rises != 1 || idx != D + 1) begin
      n_bad++;
      $display("FAIL rstmid_pulse got rises=%0d idx=%0d want 1 %0d", rises, idx, D + 1);
    end
  endtask

  task automatic test_random();
    logic [3:0] lvl;
    int run [4];
    logic r;
    lvl = '0;
    for (int ch = 0; ch < 4; ch++) run[ch] = 0;
    tick(1'b1, 4'h0);
    for (int k = 0; k < 600; k++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (run[ch] == 0) begin
          lvl[ch] = 1'($urandom_range(0, 1));
          run[ch] = $urandom_range(1, 8);
        end
        run[ch]--;
      end
      r = ($urandom_range(0, 79) == 0);
      tick(r, lvl);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.sw_in = 4'h0;
    for (int ch = 0; ch < 4; ch++) begin
      win[ch] = '0;
      last_upd[ch] = 0;
    end
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sw_debounce4.md
Name: sw_debounce4

Overview:
Four-channel switch conditioner that sits directly upstream of the 4-input AND-OR-NOT gate block. It takes raw asynchronous board switch levels, synchronizes and debounces each one, and drives clean levels onto the gate inputs a, b, c, d (sw_out[3:0] maps to {d,c,b,a}). It also produces single-cycle edge strobes for downstream event logic.

Parameters:
DEBOUNCE_CYCLES, 4, number of consecutive cycles a synchronized level must differ from sw_out before sw_out follows it (legal 2..65535; use 4 in simulation, board value set at top level)
CNT_W, 16, counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
sw_in  in  4  raw switch levels, asynchronous to clk, may bounce
sw_out  out  4  debounced levels; bit0=a, bit1=b, bit2=c, bit3=d of the gate block
sw_rise  out  4  one-cycle pulse per channel when sw_out bit goes 0->1
sw_fall  out  4  one-cycle pulse per channel when sw_out bit goes 1->0
sw_changed  out  1  OR of all sw_rise and sw_fall bits, same cycle

Behaviour:
- One clock domain (clk); reset is synchronous, active-high (rst sampled on rising edge of clk only).
- Reset: sync stages s1, s2 = 0; per-channel counters = 0; sw_out = 4'b0000; sw_rise = sw_fall = 0; sw_changed = 0. Reset mid-count discards the count; nothing updates while rst is high.
- Synchronizer: per bit, s1 <= sw_in; s2 <= s1 (2 flops, no logic between them).
- Per-channel counter, evaluated each edge with rst low:
  - s2 == sw_out: cnt <= 0; no pulse.
  - s2 != sw_out and cnt == DEBOUNCE_CYCLES-1: sw_out <= s2; cnt <= 0; sw_rise or sw_fall asserted (registered, same edge as sw_out update).
  - s2 != sw_out otherwise: cnt <= cnt+1.
- Latency: if sw_in holds a new level from edge E0 (first sampling edge), sw_out updates at edge E0+DEBOUNCE_CYCLES+1. With DEBOUNCE_CYCLES=4 that is 5 edges after E0.
- Glitch rejection: a level differing for fewer than DEBOUNCE_CYCLES consecutive cycles at s2 is ignored. Any single cycle of agreement clears the count; there is no partial credit.
- Pulses: sw_rise/sw_fall are high for exactly one cycle per accepted transition and are deasserted on the following edge. A channel never asserts rise and fall in the same cycle.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulse bits and a single sw_changed cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- sw_out is purely registered, with no combinational path from sw_in to any output.

Test Plan:
- Reset: hold rst=1 for 3 cycles with sw_in=4'hF -> sw_out=0, sw_rise=sw_fall=0, sw_changed=0 throughout; release rst, keep sw_in=4'hF -> sw_out=4'hF at 5th edge after release, sw_rise=4'hF for 1 cycle, sw_changed=1 for 1 cycle.
- Clean step (DEBOUNCE_CYCLES=4): sw_in 0->4'b0001 -> sw_out[0]=1 exactly 5 edges after first sampling edge; sw_rise=4'b0001 for one cycle; then sw_in->0 -> sw_fall=4'b0001 one cycle after the same latency.
- Glitch: sw_in[1] high for 3 cycles then low -> sw_out stays 0, no pulses. Then high for 4 cycles -> sw_out[1] goes high, single rise pulse.
- Bounce train on bit2: 1,0,1,1,0,1,1,1,1... (1-cycle dips) -> exactly one rise pulse, issued 5 edges after the last 0->1 sample.
- Simultaneous: sw_in 4'b0000->4'b1010 in one cycle -> sw_out=4'b1010 on the same edge, sw_rise=4'b1010, sw_changed high for 1 cycle; end-to-end with gate block, y matches gate truth table for {d,c,b,a}.
- Reset mid-count: sw_in[3]=1 for 3 cycles, rst=1 for 1 cycle, sw_in[3] held high -> no update until a full 5-edge window after rst is released; one rise pulse.
